alu_result_packer: RTL
======================

# alu_result_packer

Write-back end of the action-stage operand crossbar. Accepts the 64 × 32-bit ALU result containers and re-packs them into a full PHV with the 256-bit metadata/conditional tail that the crossbar forwarded unmodified. It sits between the ALU array and the next stage's PHV input. Each ALU result is paired in order with a queued tail word. Downstream backpressure is absorbed in a 2-entry output queue and reflected upstream to the crossbar via `ready_out`.

## Interface
- `STAGE_ID`, 0, stage index (informational only).
- `PHV_LEN`, 4*8*64+256, output PHV width.
- `width_4B`, 32, container width.
- `FIFO_DEPTH`, 4, tail-FIFO depth; power of 2, ≥ 4.

Ports:
- `clk` in 1: single clock; all logic is posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `remain_in` in 256: metadata tail from the crossbar (`phv_remain_data`).
- `remain_in_valid` in 1: tail-push strobe; this is the crossbar's `alu_in_valid`.
- `alu_out_4B` in width_4B*64: ALU results; container i is at `[(i+1)*32-1 -: 32]`.
- `alu_out_valid` in 1: ALU result strobe. ALU latency is fixed, so results arrive in issue order.
- `phv_out` out PHV_LEN: packed PHV.
- `phv_out_valid` out 1: the output queue is non-empty.
- `ready_in` in 1: downstream ready.
- `ready_out` out 1: registered; upstream may issue while high.
- `err_cnt` out 16: present only with `PACKER_ERR_CNT_EN`.

## Operation
**Packing**
- Container i goes to `phv_out[PHV_LEN-1-32*(63-i) -: 32]`.
- `phv_out[255:0]` carries the tail word.
- No arithmetic is performed; bits pass through unchanged.

**Tail FIFO (`FIFO_DEPTH` entries)**
- Push on `remain_in_valid`.
- Pop on `alu_out_valid` when the FIFO is non-empty.
- Push while full is accepted only if a pop occurs in the same cycle; otherwise the push is dropped (overflow).
- `alu_out_valid` with the FIFO empty drops the result (underflow); no output is produced.
- Pointers wrap modulo `FIFO_DEPTH`. The count is held separately, so full and empty are distinguishable.

**Output queue: state machine EMPTY / ONE / TWO**
- Head register drives `phv_out`; a skid register holds the second entry.
- Enqueue occurs on a successful merge (`alu_out_valid` with the FIFO non-empty).
- Dequeue occurs on `phv_out_valid && ready_in`.
- EMPTY → ONE on enqueue.
- ONE: enqueue without dequeue → TWO; dequeue without enqueue → EMPTY; enqueue with dequeue → stays ONE, and the head loads the new word.
- TWO: dequeue → ONE, and the skid moves to the head. An enqueue arriving in the same cycle is written to the skid (stays TWO).
- TWO with enqueue and no dequeue: the new word is dropped (overflow). The FIFO still pops, to keep pairing aligned.
- `phv_out` holds stable while `phv_out_valid && !ready_in`.

**Backpressure**
- `ready_out` next value = (next FIFO count ≤ `FIFO_DEPTH`-2) && (next queue state ≠ TWO).
- Upstream is responsible for not issuing while `ready_out` is low. Drops occur only if it violates this.

## Timing
- Latency is 1 cycle: `alu_out_valid` at cycle N → `phv_out_valid` at N+1, when the queue is EMPTY or dequeuing.
- `ready_out` reflects cycle-N events at N+1.
- A tail pushed at cycle N may be popped at N+1 at the earliest. Same-cycle push into an empty FIFO followed by a pop is not bypassed; the result is an underflow.
- Reset values:
  - `phv_out` = 0, `phv_out_valid` = 0, `ready_out` = 1, `err_cnt` = 0.
  - FIFO is empty; the state machine is EMPTY.
- Reset asserted mid-operation discards all queued tails and outputs immediately, since reset is asynchronous.

## Configuration
- `PACKER_ERR_CNT_EN` defined:
  - `err_cnt` port is present.
  - Increments by 1 per underflow, tail-overflow, or output-overflow event, saturating at 16'hFFFF.
  - Simultaneous events in one cycle add their sum, also saturating.
- Not defined: the port and counter are absent; drops are silent.

## Test plan
- Single packet, `ready_in`=1:
  - Stimulus: push tail 256'hA5…; two cycles later, results with container i = i.
  - Required: next cycle `phv_out_valid`=1, `phv_out[255:0]`=A5…, and container 63 at `[PHV_LEN-1 -: 32]` = 32'd63.
- Backpressure:
  - Stimulus: `ready_in`=0; three tails pushed; two results delivered.
  - Required: state TWO, `ready_out`=0, head holds packet 1 stable.
  - Then: raise `ready_in` → packets 1, 2 emitted on consecutive cycles, in order.
- FIFO full with simultaneous push and pop:
  - Stimulus: 4 tails queued, then push + result in the same cycle.
  - Required: push accepted, count stays 4, no error.
- Underflow:
  - Stimulus: `alu_out_valid` with the FIFO empty.
  - Required: no output; `err_cnt` 0→1 (with macro).
- Async reset:
  - Stimulus: assert `rst_n`=0 while in state TWO with 3 tails queued.
  - Required: outputs go to their reset values without a clock edge. After release, a single packet round-trips correctly.
- Saturation (macro): force 65 540 underflows → `err_cnt` = 16'hFFFF.

Source files
------------

// File: rtl/alu_result_packer.sv
// alu_result_packer: write-back end of the action-stage operand crossbar.
// Pairs each ALU result vector (64 x 32-bit containers) in issue order with a
// queued 256-bit metadata tail and presents the packed PHV through a 2-entry
// output queue (head + skid) with registered upstream backpressure.
// Optional feature macro: PACKER_ERR_CNT_EN adds a saturating 16-bit drop
// counter on port err_cnt (underflow, tail overflow, output overflow).
module alu_result_packer #(
  parameter int STAGE_ID   = 0,
  parameter int PHV_LEN    = 4*8*64+256,
  parameter int width_4B   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [255:0]            remain_in,
  input  logic                    remain_in_valid,
  input  logic [width_4B*64-1:0]  alu_out_4B,
  input  logic                    alu_out_valid,
  output logic [PHV_LEN-1:0]      phv_out,
  output logic                    phv_out_valid,
  input  logic                    ready_in,
  output logic                    ready_out
`ifdef PACKER_ERR_CNT_EN
  ,
  output logic [15:0]             err_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HIWAT_C = CW'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  // Stage index is informational only.
  logic [31:0] stage_id_unused;
  assign stage_id_unused = STAGE_ID;

  // Tail FIFO state
  logic [255:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pop, push_ok, underflow, tail_ovf;

  // Output queue state
  state_t              state_q, state_d;
  logic [PHV_LEN-1:0]  head_q, head_d;
  logic [PHV_LEN-1:0]  skid_q, skid_d;
  logic [PHV_LEN-1:0]  merged;
  logic                deq, out_ovf;
  logic                ready_q, ready_d;

  // Containers already sit in ascending order above the tail, so the merge
  // is a plain concatenation.
  assign merged = {alu_out_4B, mem_q[rd_ptr_q]};

  // Tail FIFO pointer/count next state; a full FIFO accepts a push only
  // when a pop frees the slot in the same cycle.
  always_comb begin
    pop       = alu_out_valid && (cnt_q != '0);
    underflow = alu_out_valid && (cnt_q == '0);
    push_ok   = remain_in_valid && ((cnt_q != DEPTH_C) || pop);
    tail_ovf  = remain_in_valid && !push_ok;
    wr_ptr_d  = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d     = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Output queue FSM: head drives phv_out, skid holds the second entry.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    out_ovf = 1'b0;
    deq     = (state_q != S_EMPTY) && ready_in;
    case (state_q)
      S_EMPTY: begin
        if (pop) begin
          state_d = S_ONE;
          head_d  = merged;
        end
      end
      S_ONE: begin
        if (pop && !deq) begin
          state_d = S_TWO;
          skid_d  = merged;
        end else if (pop && deq) begin
          head_d  = merged;
        end else if (deq) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (deq) begin
          head_d = skid_q;
          if (pop) skid_d  = merged;
          else     state_d = S_ONE;
        end else if (pop) begin
          out_ovf = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    ready_d = (cnt_d <= HIWAT_C) && (state_d != S_TWO);
  end

  // Control registers and the visible head word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= S_EMPTY;
      head_q   <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      head_q   <= head_d;
      ready_q  <= ready_d;
    end
  end

  // Data-only storage: tail entries and skid word need no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= remain_in;
    skid_q <= skid_d;
  end

  assign phv_out       = head_q;
  assign phv_out_valid = (state_q != S_EMPTY);
  assign ready_out     = ready_q;

`ifdef PACKER_ERR_CNT_EN
  logic [15:0] err_q, err_d;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Sum of drop events this cycle, saturating at all-ones
  always_comb begin
    err_d = sat_add16(err_q, 2'({1'b0, underflow} + {1'b0, tail_ovf} + {1'b0, out_ovf}));
  end

  // Drop counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  logic drops_unused;
  assign drops_unused = underflow | tail_ovf | out_ovf;
`endif

endmodule
